// File: rtl/sdram_byte_port_if.sv
// sdram_bus: word-wide SDRAM request/ack channel between a client and the controller.
interface sdram_bus #(parameter int ADDR_BITS = 22);
  logic                 req;
  logic                 we;
  logic                 ack;
  logic [ADDR_BITS-1:0] address;
  logic [15:0]          data_write;
  logic [15:0]          data_read;
  logic [1:0]           wm;
  modport controller(output req, address, data_write, we, wm, input ack, data_read);
  modport memory(input req, address, data_write, we, wm, output ack, data_read);
endinterface

// File: rtl/sdram_byte_port.sv
// sdram_byte_port: byte-wide host port onto a 16-bit SDRAM bus with a one-word read cache.
module sdram_byte_port #(
  parameter int ADDR_BITS = 22
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_BITS:0] host_addr,
  input  logic               host_rd,
  input  logic               host_wr,
  input  logic [7:0]         host_wdata,
  output logic [7:0]         host_rdata,
  output logic               host_rd_valid,
  output logic               host_busy,
  input  logic               invalidate,
  sdram_bus.controller       mem
);
  typedef enum logic {IDLE, WAIT_ACK} state_t;
  state_t state, state_n;
  logic                 req, we, sel;
  logic [1:0]           wm;
  logic [ADDR_BITS-1:0] address, cache_tag;
  logic [15:0]          data_write, cache_data;
  logic                 cache_valid;
  logic [ADDR_BITS-1:0] word;
  logic                 hit, accept_wr, accept_rd, done, wr_hit;
  assign word      = host_addr[ADDR_BITS:1];
  assign hit       = cache_valid && cache_tag == word;
  assign accept_wr = state == IDLE && host_wr;
  assign accept_rd = state == IDLE && host_rd && !host_wr;
  assign done      = state == WAIT_ACK && mem.ack;
  assign wr_hit    = cache_valid && cache_tag == address;
  assign host_busy = state == WAIT_ACK;
  assign mem.req        = req;
  assign mem.we         = we;
  assign mem.wm         = wm;
  assign mem.address    = address;
  assign mem.data_write = data_write;
  always_comb begin
    state_n = state;
    state_n = (state == IDLE) ? ((accept_wr || (accept_rd && !hit)) ? WAIT_ACK : IDLE)
                              : (mem.ack ? IDLE : WAIT_ACK);
  end
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      req           <= 1'b0;
      we            <= 1'b0;
      wm            <= 2'b11;
      sel           <= 1'b0;
      address       <= '0;
      data_write    <= '0;
      host_rd_valid <= 1'b0;
      host_rdata    <= '0;
      cache_valid   <= 1'b0;
      cache_tag     <= '0;
      cache_data    <= '0;
    end else begin
      req           <= accept_wr || (accept_rd && !hit);
      host_rd_valid <= (accept_rd && hit) || (done && !we);
      // Bus fields are only loaded on acceptance so they stay put until ack.
      if (accept_wr) begin
        we         <= 1'b1;
        wm         <= host_addr[0] ? 2'b01 : 2'b10;
        address    <= word;
        data_write <= {host_wdata, host_wdata};
        sel        <= host_addr[0];
      end else if (accept_rd && !hit) begin
        we      <= 1'b0;
        wm      <= 2'b00;
        address <= word;
        sel     <= host_addr[0];
      end
      if (accept_rd && hit) host_rdata <= host_addr[0] ? cache_data[15:8] : cache_data[7:0];
      // A fill racing an invalidate wins, so the clear sits before it.
      if (invalidate) cache_valid <= 1'b0;
      if (done && !we) begin
        host_rdata  <= sel ? mem.data_read[15:8] : mem.data_read[7:0];
        cache_data  <= mem.data_read;
        cache_tag   <= address;
        cache_valid <= 1'b1;
      end else if (done && wr_hit) begin
        cache_data <= sel ? {data_write[15:8], cache_data[7:0]} : {cache_data[15:8], data_write[7:0]};
      end
    end
  end
endmodule

// File: tb/tb_sdram_byte_port.sv
// tb_sdram_byte_port: table-driven check of sdram_byte_port plus directed corner-case sequences.
module tb_sdram_byte_port;
  localparam int AB = 22;
  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [AB:0]   host_addr = '0;
  logic          host_rd = 1'b0;
  logic          host_wr = 1'b0;
  logic [7:0]    host_wdata = '0;
  logic [7:0]    host_rdata;
  logic          host_rd_valid;
  logic          host_busy;
  logic          invalidate = 1'b0;
  int            total = 0;
  int            bad = 0;
  int            req_cnt = 0;
  int            rdv_cnt = 0;
  logic [7:0]    exp_last = '0;
  sdram_bus #(.ADDR_BITS(AB)) bus();
  sdram_byte_port #(.ADDR_BITS(AB)) dut (
    .clk(clk), .reset(reset), .host_addr(host_addr), .host_rd(host_rd), .host_wr(host_wr),
    .host_wdata(host_wdata), .host_rdata(host_rdata), .host_rd_valid(host_rd_valid),
    .host_busy(host_busy), .invalidate(invalidate), .mem(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (bus.req) req_cnt <= req_cnt + 1;
    if (host_rd_valid) rdv_cnt <= rdv_cnt + 1;
  end
  typedef struct {
    logic          rd;
    logic          wr;
    logic [AB:0]   addr;
    logic [7:0]    wdata;
    logic [15:0]   ack_data;
    int            delay;
    logic          exp_req;
    logic          exp_we;
    logic [1:0]    exp_wm;
    logic [AB-1:0] exp_addr;
    logic [15:0]   exp_dw;
    logic          exp_rdv;
    logic [7:0]    exp_rdata;
  } vec_t;
  vec_t tbl [12];
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h", nm, act, exp);
    end
  endtask
  task automatic do_op(input vec_t v, input string nm);
    host_addr  = v.addr;
    host_wdata = v.wdata;
    host_rd    = v.rd;
    host_wr    = v.wr;
    cyc;
    host_rd = 1'b0;
    host_wr = 1'b0;
    chk({nm, ".req"}, 32'(bus.req), 32'(v.exp_req));
    chk({nm, ".busy"}, 32'(host_busy), 32'(v.exp_req));
    if (v.exp_req) begin
      chk({nm, ".we"}, 32'(bus.we), 32'(v.exp_we));
      chk({nm, ".wm"}, 32'(bus.wm), 32'(v.exp_wm));
      chk({nm, ".address"}, 32'(bus.address), 32'(v.exp_addr));
      if (v.exp_we) chk({nm, ".data_write"}, 32'(bus.data_write), 32'(v.exp_dw));
      for (int i = 0; i < v.delay; i++) begin
        cyc;
        chk({nm, ".req_drop"}, 32'(bus.req), 32'd0);
        chk({nm, ".addr_hold"}, 32'(bus.address), 32'(v.exp_addr));
        chk({nm, ".wm_hold"}, 32'(bus.wm), 32'(v.exp_wm));
      end
      bus.ack       = 1'b1;
      bus.data_read = v.ack_data;
      cyc;
      bus.ack       = 1'b0;
      bus.data_read = '0;
      chk({nm, ".busy_after_ack"}, 32'(host_busy), 32'd0);
    end
    chk({nm, ".rd_valid"}, 32'(host_rd_valid), 32'(v.exp_rdv));
    if (v.exp_rdv) begin
      chk({nm, ".rdata"}, 32'(host_rdata), 32'(v.exp_rdata));
      exp_last = v.exp_rdata;
    end
    cyc;
    chk({nm, ".rd_valid_end"}, 32'(host_rd_valid), 32'd0);
    chk({nm, ".rdata_hold"}, 32'(host_rdata), 32'(exp_last));
  endtask
  initial begin
    int rc0, rv0;
    vec_t v;
    bus.ack       = 1'b0;
    bus.data_read = '0;
    tbl[0]  = '{0, 1, 23'h3,      8'hA5, 16'h0,    2, 1, 1, 2'b01, 22'h1,      16'hA5A5, 0, 8'h00};
    tbl[1]  = '{1, 0, 23'h2,      8'h00, 16'h1234, 1, 1, 0, 2'b00, 22'h1,      16'h0,    1, 8'h34};
    tbl[2]  = '{1, 0, 23'h3,      8'h00, 16'h0,    0, 0, 0, 2'b00, 22'h0,      16'h0,    1, 8'h12};
    tbl[3]  = '{0, 1, 23'h2,      8'hFF, 16'h0,    0, 1, 1, 2'b10, 22'h1,      16'hFFFF, 0, 8'h00};
    tbl[4]  = '{1, 0, 23'h2,      8'h00, 16'h0,    0, 0, 0, 2'b00, 22'h0,      16'h0,    1, 8'hFF};
    tbl[5]  = '{1, 0, 23'h3,      8'h00, 16'h0,    0, 0, 0, 2'b00, 22'h0,      16'h0,    1, 8'h12};
    tbl[6]  = '{0, 1, 23'h10,     8'h5A, 16'h0,    3, 1, 1, 2'b10, 22'h8,      16'h5A5A, 0, 8'h00};
    tbl[7]  = '{1, 0, 23'h3,      8'h00, 16'h0,    0, 0, 0, 2'b00, 22'h0,      16'h0,    1, 8'h12};
    tbl[8]  = '{1, 1, 23'h5,      8'h3C, 16'h0,    1, 1, 1, 2'b01, 22'h2,      16'h3C3C, 0, 8'h00};
    tbl[9]  = '{1, 0, 23'h5,      8'h00, 16'hBEEF, 2, 1, 0, 2'b00, 22'h2,      16'h0,    1, 8'hBE};
    tbl[10] = '{1, 0, 23'h4,      8'h00, 16'h0,    0, 0, 0, 2'b00, 22'h0,      16'h0,    1, 8'hEF};
    tbl[11] = '{1, 0, 23'h7FFFFF, 8'h00, 16'hC3D2, 1, 1, 0, 2'b00, 22'h3FFFFF, 16'h0,    1, 8'hC3};
    repeat (3) cyc;
    chk("reset.req", 32'(bus.req), 32'd0);
    chk("reset.we", 32'(bus.we), 32'd0);
    chk("reset.wm", 32'(bus.wm), 32'd3);
    chk("reset.rd_valid", 32'(host_rd_valid), 32'd0);
    chk("reset.busy", 32'(host_busy), 32'd0);
    chk("reset.rdata", 32'(host_rdata), 32'd0);
    reset = 1'b0;
    cyc;
    for (int i = 0; i < 12; i++) do_op(tbl[i], $sformatf("vec%0d", i));
    // Strobes while busy must not start another transaction.
    rc0 = req_cnt;
    rv0 = rdv_cnt;
    host_addr = 23'h6; host_wdata = 8'h11; host_wr = 1'b1;
    cyc;
    host_wr = 1'b0;
    chk("busy_strobe.busy", 32'(host_busy), 32'd1);
    host_addr = 23'h8; host_rd = 1'b1; host_wr = 1'b1;
    cyc;
    cyc;
    host_rd = 1'b0; host_wr = 1'b0;
    bus.ack = 1'b1;
    cyc;
    bus.ack = 1'b0;
    cyc;
    cyc;
    chk("busy_strobe.req_count", 32'(req_cnt - rc0), 32'd1);
    chk("busy_strobe.no_rdv", 32'(rdv_cnt - rv0), 32'd0);
    // Ack while idle is ignored.
    rv0 = rdv_cnt;
    bus.ack = 1'b1; bus.data_read = 16'h0BAD;
    cyc;
    cyc;
    bus.ack = 1'b0; bus.data_read = '0;
    cyc;
    chk("idle_ack.busy", 32'(host_busy), 32'd0);
    chk("idle_ack.no_rdv", 32'(rdv_cnt - rv0), 32'd0);
    v = '{1, 0, 23'h7FFFFE, 8'h00, 16'h0, 0, 0, 0, 2'b00, 22'h0, 16'h0, 1, 8'hD2};
    do_op(v, "idle_ack.hit");
    invalidate = 1'b1;
    cyc;
    invalidate = 1'b0;
    v = '{1, 0, 23'h7FFFFE, 8'h00, 16'hC3D2, 1, 1, 0, 2'b00, 22'h3FFFFF, 16'h0, 1, 8'hD2};
    do_op(v, "inval.miss");
    // Invalidate coinciding with a fill: the fill wins.
    host_addr = 23'h20; host_rd = 1'b1;
    cyc;
    host_rd = 1'b0;
    chk("fill_inval.req", 32'(bus.req), 32'd1);
    bus.ack = 1'b1; bus.data_read = 16'h5566; invalidate = 1'b1;
    cyc;
    bus.ack = 1'b0; bus.data_read = '0; invalidate = 1'b0;
    chk("fill_inval.rd_valid", 32'(host_rd_valid), 32'd1);
    chk("fill_inval.rdata", 32'(host_rdata), 32'h66);
    exp_last = 8'h66;
    cyc;
    v = '{1, 0, 23'h21, 8'h00, 16'h0, 0, 0, 0, 2'b00, 22'h0, 16'h0, 1, 8'h55};
    do_op(v, "fill_inval.hit");
    // Reset while waiting for ack abandons the transaction.
    rv0 = rdv_cnt;
    host_addr = 23'h40; host_rd = 1'b1;
    cyc;
    host_rd = 1'b0;
    chk("rst_wait.busy", 32'(host_busy), 32'd1);
    reset = 1'b1;
    cyc;
    reset = 1'b0;
    exp_last = 8'h00;
    chk("rst_wait.busy_clr", 32'(host_busy), 32'd0);
    chk("rst_wait.wm", 32'(bus.wm), 32'd3);
    chk("rst_wait.rdata", 32'(host_rdata), 32'd0);
    bus.ack = 1'b1; bus.data_read = 16'h9999;
    cyc;
    bus.ack = 1'b0; bus.data_read = '0;
    cyc;
    chk("rst_wait.late_ack_busy", 32'(host_busy), 32'd0);
    chk("rst_wait.no_rdv", 32'(rdv_cnt - rv0), 32'd0);
    v = '{1, 0, 23'h21, 8'h00, 16'h5566, 1, 1, 0, 2'b00, 22'h10, 16'h0, 1, 8'h55};
    do_op(v, "rst_wait.miss");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sdram_byte_port.md
SDRAM_BYTE_PORT -- requirements
Module: sdram_byte_port

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 22, meaning SDRAM word-address width (bank + column + row).
REQ-002 SHALL have port clk, input, 1 bit: the single clock, shared with the SDRAM controller.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port host_addr, input, ADDR_BITS+1 bits: byte address; bit 0 selects the byte, bits [ADDR_BITS:1] give the word address.
REQ-005 SHALL have port host_rd, input, 1 bit: read strobe, sampled each cycle.
REQ-006 SHALL have port host_wr, input, 1 bit: write strobe, sampled each cycle.
REQ-007 SHALL have port host_wdata, input, 8 bits: write byte.
REQ-008 SHALL have port host_rdata, output, 8 bits: read byte, valid while host_rd_valid=1.
REQ-009 SHALL have port host_rd_valid, output, 1 bit: one-cycle pulse marking read data.
REQ-010 SHALL have port host_busy, output, 1 bit: a memory transaction is outstanding.
REQ-011 SHALL have port invalidate, input, 1 bit: clears the read-cache valid flag.
REQ-012 SHALL have port mem, sdram_bus.controller modport, driving req, address[ADDR_BITS-1:0], data_write[15:0], we and wm[1:0], and receiving ack and data_read[15:0].

Function
REQ-013 SHALL implement FSM states IDLE and WAIT_ACK; host_busy = (state == WAIT_ACK).
REQ-014 SHALL accept strobes only in IDLE; strobes during WAIT_ACK SHALL be ignored, with no queuing.
REQ-015 If host_wr and host_rd are both high in IDLE, SHALL perform the write and drop the read.
REQ-016 Write accepted at cycle T: at T+1, SHALL drive mem.req=1 for exactly one cycle, mem.we=1, mem.address=host_addr[ADDR_BITS:1], mem.data_write={wdata,wdata}; state SHALL become WAIT_ACK.
REQ-017 Write mask (1 = byte masked): SHALL drive wm=2'b10 when addr[0]=0 and wm=2'b01 when addr[0]=1.
REQ-018 SHALL hold address, data_write, we and wm stable from the req cycle through the ack cycle.
REQ-019 SHALL keep a one-word read cache holding valid, word tag and 16-bit data.
REQ-020 Read hit (valid and tag == addr[ADDR_BITS:1]) at T: SHALL pulse host_rd_valid at T+1 with the selected byte, issue no req and not assert busy.
REQ-021 Read miss at T: SHALL drive req=1 at T+1 for one cycle with we=0 and wm=2'b00, then go to WAIT_ACK.
REQ-022 Read miss, ack in cycle A: SHALL load the cache with mem.data_read, set the tag, set valid=1, and pulse host_rd_valid at A+1.
REQ-023 Byte select: SHALL return [7:0] when addr[0]=0 and [15:8] when addr[0]=1.
REQ-024 On write ack with a cache hit on the same word, SHALL update the written byte in the cache; a non-matching write SHALL leave the cache unchanged.
REQ-025 On write ack, SHALL return to IDLE at A+1 with no host_rd_valid pulse.
REQ-026 A new strobe is accepted in the cycle after ack, when busy=0.
REQ-027 SHALL ignore ack while in IDLE.
REQ-028 SHALL clear valid when invalidate=1 in any state; if invalidate coincides with a read-miss ack, valid SHALL end 1, since the fill wins.
REQ-029 SHALL wait for ack indefinitely, with no timeout.
REQ-030 host_rdata SHALL hold its last value when host_rd_valid=0.

Reset
REQ-031 SHALL set, on reset: state=IDLE, req=0, we=0, wm=2'b11, host_rd_valid=0, host_busy=0, host_rdata=0, cache valid=0.
REQ-032 Reset asserted during WAIT_ACK SHALL abandon the transaction; a late ack after reset SHALL be ignored, per REQ-027.

Verification
REQ-033 Write 0xA5 to byte addr 0x000003 -> one req pulse, address 0x000001, data_write 0xA5A5, wm 2'b01, we 1; busy until ack.
REQ-034 Read 0x000002 (miss), memory returns 0x1234 -> req we=0, wm 2'b00; rdata 0x34 one cycle after ack. Then read 0x000003 -> hit, no req, rdata 0x12 next cycle.
REQ-035 After REQ-034, write 0xFF to 0x000002 then read 0x000002 -> hit returns 0xFF; cache word 0x12FF.
REQ-036 host_rd and host_wr both high in IDLE -> only a write req; no rd_valid pulse. A strobe while busy -> no extra req.
REQ-037 Pulse invalidate, then read 0x000002 -> miss, req issued.
REQ-038 Assert reset in WAIT_ACK, then ack -> state IDLE, no rd_valid, valid=0.
